// File: rtl/axi_rom_read_arbiter_if.sv
// AXI4 read-channel bundle used on both sides of the ROM read arbiter.
// The master modport drives AR and rready; the slave modport answers them.
interface axi_rom_read_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [1:0]            arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic [3:0]            arqos;
    logic [3:0]            arregion;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
        output arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    // Sideband AR fields are not offered here: the arbiter regenerates them as constants.
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rom_read_arbiter.sv
// Two-master round-robin AXI4 read arbiter in front of a single instruction ROM slave.
// One burst outstanding at a time; grant held until the RLAST beat handshakes.
module axi_rom_read_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    axi_rom_read_arbiter_if.slave  m0,
    axi_rom_read_arbiter_if.slave  m1,
    axi_rom_read_arbiter_if.master s_axi,
    output logic                   grant,
    output logic                   busy,
    output logic                   len_err
);

    typedef enum logic [1:0] {StIdle, StAr, StR} state_e;

    state_e                state_q, state_d;
    logic                  prio_q, prio_d;
    logic                  grant_q, grant_d;
    logic                  len_err_q, len_err_d;
    logic                  arvalid_q, arvalid_d;
    logic [ID_WIDTH-1:0]   ar_id_q, ar_id_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic [7:0]            ar_len_q, ar_len_d;
    logic [2:0]            ar_size_q, ar_size_d;
    logic [1:0]            ar_burst_q, ar_burst_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic [7:0]            exp_last_q, exp_last_d;
    logic                  win;

    // Master 1 wins when alone, or when both request and the pointer names it.
    assign win = m1.arvalid & (~m0.arvalid | prio_q);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= StIdle;
            prio_q     <= 1'b0;
            grant_q    <= 1'b0;
            len_err_q  <= 1'b0;
            arvalid_q  <= 1'b0;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            beat_cnt_q <= '0;
            exp_last_q <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            grant_q    <= grant_d;
            len_err_q  <= len_err_d;
            arvalid_q  <= arvalid_d;
            ar_id_q    <= ar_id_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            beat_cnt_q <= beat_cnt_d;
            exp_last_q <= exp_last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        grant_d    = grant_q;
        len_err_d  = len_err_q;
        arvalid_d  = arvalid_q;
        ar_id_d    = ar_id_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        beat_cnt_d = beat_cnt_q;
        exp_last_d = exp_last_q;
        case (state_q)
            StIdle: begin
                if (m0.arvalid | m1.arvalid) begin
                    grant_d    = win;
                    ar_id_d    = win ? m1.arid    : m0.arid;
                    ar_addr_d  = win ? m1.araddr  : m0.araddr;
                    ar_len_d   = win ? m1.arlen   : m0.arlen;
                    ar_size_d  = win ? m1.arsize  : m0.arsize;
                    ar_burst_d = win ? m1.arburst : m0.arburst;
                    arvalid_d  = 1'b1;
                    state_d    = StAr;
                end
            end
            StAr: begin
                if (s_axi.arready) begin
                    arvalid_d  = 1'b0;
                    beat_cnt_d = '0;
                    exp_last_d = ar_len_q;
                    state_d    = StR;
                end
            end
            StR: begin
                if (s_axi.rvalid & s_axi.rready) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (s_axi.rlast) begin
                        state_d = StIdle;
                        prio_d  = ~grant_q;
                        if (beat_cnt_q != exp_last_q) len_err_d = 1'b1;
                    end else if (beat_cnt_q == exp_last_q) begin
                        // Late rlast: flag it but keep draining until the slave ends the burst.
                        len_err_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m0.arready = (state_q == StAr) & ~grant_q & arvalid_q & s_axi.arready;
        m1.arready = (state_q == StAr) &  grant_q & arvalid_q & s_axi.arready;
        m0.rvalid  = (state_q == StR) & ~grant_q & s_axi.rvalid;
        m1.rvalid  = (state_q == StR) &  grant_q & s_axi.rvalid;
        m0.rid     = '0;
        m0.rdata   = {DATA_WIDTH{1'b0}};
        m0.rresp   = '0;
        m0.rlast   = 1'b0;
        m1.rid     = '0;
        m1.rdata   = {DATA_WIDTH{1'b0}};
        m1.rresp   = '0;
        m1.rlast   = 1'b0;
        if (state_q == StR && !grant_q) begin
            m0.rid   = s_axi.rid;
            m0.rdata = s_axi.rdata;
            m0.rresp = s_axi.rresp;
            m0.rlast = s_axi.rlast;
        end
        if (state_q == StR && grant_q) begin
            m1.rid   = s_axi.rid;
            m1.rdata = s_axi.rdata;
            m1.rresp = s_axi.rresp;
            m1.rlast = s_axi.rlast;
        end
        s_axi.rready   = (state_q == StR) & (grant_q ? m1.rready : m0.rready);
        s_axi.arid     = ar_id_q;
        s_axi.araddr   = ar_addr_q;
        s_axi.arlen    = ar_len_q;
        s_axi.arsize   = ar_size_q;
        s_axi.arburst  = ar_burst_q;
        s_axi.arvalid  = arvalid_q;
        s_axi.arlock   = 2'b00;
        s_axi.arcache  = 4'b0000;
        s_axi.arprot   = 3'b100;
        s_axi.arqos    = 4'b0000;
        s_axi.arregion = 4'b0000;
        grant          = grant_q;
        busy           = (state_q != StIdle);
        len_err        = len_err_q;
    end

endmodule

// File: tb/tb_axi_rom_read_arbiter.sv
// Scenario bench for axi_rom_read_arbiter: a cycle-stepped ROM slave model plus a beat
// scoreboard filled when a master's AR handshakes and drained as beats reach the masters.
module tb_axi_rom_read_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 4;

    typedef struct packed {
        logic        mst;
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic ACLK = 1'b0;
    logic ARESET;
    logic grant, busy, len_err;

    axi_rom_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) m0_if ();
    axi_rom_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) m1_if ();
    axi_rom_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) s_if ();

    axi_rom_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .m0     (m0_if),
        .m1     (m1_if),
        .s_axi  (s_if),
        .grant  (grant),
        .busy   (busy),
        .len_err(len_err)
    );

    always #5 ACLK = ~ACLK;

    beat_t       exp_q[$];
    int          ar_order[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          ar_pulses[2];
    int          m_beats[2];
    int          sl_state, sl_wait, sl_delay, sl_rlast_at, sl_beat;
    logic        sl_override;
    logic [31:0] sl_addr;
    logic [7:0]  sl_len;
    logic [3:0]  sl_id;
    logic        h_s_ar, h_r, obs_s_rready;

    function automatic logic [31:0] data_of(input logic [31:0] addr, input int beat);
        if (sl_override) return 32'hDEADBEEF;
        return (addr + 32'(beat * 4)) ^ 32'h5A5A_0000;
    endfunction

    function automatic int last_idx(input logic [7:0] len);
        return (sl_rlast_at >= 0) ? sl_rlast_at : int'(len);
    endfunction

    function automatic bit idle_done();
        return busy === 1'b0 && m0_if.arvalid === 1'b0 && m1_if.arvalid === 1'b0 &&
               sl_state == 0 && exp_q.size() == 0;
    endfunction

    task automatic push_expected(input logic mst, input logic [3:0] id, input logic [31:0] addr,
                                 input logic [7:0] len);
        beat_t b;
        int    li;
        li = last_idx(len);
        for (int i = 0; i <= li; i++) begin
            b.mst  = mst;
            b.id   = id;
            b.data = data_of(addr, i);
            b.resp = {1'b0, i[0]};
            b.last = (i == li);
            exp_q.push_back(b);
        end
    endtask

    task automatic m_req(input logic mst, input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len);
        if (mst) begin
            m1_if.arid = id; m1_if.araddr = addr; m1_if.arlen = len;
            m1_if.arsize = 3'd2; m1_if.arburst = 2'b01; m1_if.arvalid = 1'b1;
        end else begin
            m0_if.arid = id; m0_if.araddr = addr; m0_if.arlen = len;
            m0_if.arsize = 3'd2; m0_if.arburst = 2'b01; m0_if.arvalid = 1'b1;
        end
    endtask

    // Called 2 time units after a rising edge: sample at +3, step the models after the next edge.
    task automatic tick();
        beat_t got, want;
        logic  h0, h1, hm0, hm1;
        #1;
        h_s_ar       = s_if.arvalid && s_if.arready;
        h_r          = s_if.rvalid && s_if.rready;
        obs_s_rready = s_if.rready;
        h0  = m0_if.arvalid && m0_if.arready;
        h1  = m1_if.arvalid && m1_if.arready;
        hm0 = m0_if.rvalid && m0_if.rready;
        hm1 = m1_if.rvalid && m1_if.rready;
        ar_pulses[0] += int'(m0_if.arready);
        ar_pulses[1] += int'(m1_if.arready);
        if (h_s_ar) begin
            sl_addr = s_if.araddr; sl_len = s_if.arlen; sl_id = s_if.arid;
        end
        if (h0) begin
            ar_order.push_back(0);
            push_expected(1'b0, m0_if.arid, m0_if.araddr, m0_if.arlen);
        end
        if (h1) begin
            ar_order.push_back(1);
            push_expected(1'b1, m1_if.arid, m1_if.araddr, m1_if.arlen);
        end
        if (hm0 || hm1) begin
            m_beats[0] += int'(hm0);
            m_beats[1] += int'(hm1);
            got = hm1 ? {1'b1, m1_if.rid, m1_if.rdata, m1_if.rresp, m1_if.rlast}
                      : {1'b0, m0_if.rid, m0_if.rdata, m0_if.rresp, m0_if.rlast};
            n_checks++;
            if (hm0 && hm1) begin
                $display("FAIL sb_beat: both masters handshook a beat, got %h", got);
            end else if (exp_q.size() == 0) begin
                $display("FAIL sb_beat: unexpected beat %h, none pending", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) $display("FAIL sb_beat: got %h want %h", got, want);
                else n_pass++;
            end
        end
        @(posedge ACLK);
        #2;
        if (h0) m0_if.arvalid = 1'b0;
        if (h1) m1_if.arvalid = 1'b0;
        if (h_r) begin
            if (sl_beat == last_idx(sl_len)) sl_state = 0;
            sl_beat++;
        end
        s_if.arready = 1'b0;
        if (h_s_ar) begin
            sl_state = 2;
            sl_beat  = 0;
        end else if (sl_state == 0 && s_if.arvalid === 1'b1) begin
            sl_wait  = sl_delay;
            sl_state = 1;
        end
        if (sl_state == 1) begin
            if (sl_wait == 0) s_if.arready = 1'b1;
            else sl_wait--;
        end
        s_if.rvalid = (sl_state == 2);
        s_if.rdata  = data_of(sl_addr, sl_beat);
        s_if.rid    = sl_id;
        s_if.rresp  = {1'b0, sl_beat[0]};
        s_if.rlast  = (sl_state == 2) && (sl_beat == last_idx(sl_len));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!idle_done() && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (!idle_done()) $display("FAIL wait_idle: not idle after %0d cycles, busy=%b", n, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        tick();
        tick();
        ARESET = 1'b0;
        n_checks++;
        if ({busy, grant, len_err, s_if.arvalid, s_if.rready} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000",
                     {busy, grant, len_err, s_if.arvalid, s_if.rready});
        else n_pass++;
        n_checks++;
        if ({s_if.arid, s_if.araddr, s_if.arlen, s_if.arsize, s_if.arburst} !== 49'd0)
            $display("FAIL reset_ar_regs: got %h want 0",
                     {s_if.arid, s_if.araddr, s_if.arlen, s_if.arsize, s_if.arburst});
        else n_pass++;
        n_checks++;
        if ({s_if.arlock, s_if.arcache, s_if.arprot, s_if.arqos, s_if.arregion} !==
            {2'b00, 4'h0, 3'b100, 4'h0, 4'h0})
            $display("FAIL sideband: got %h want %h",
                     {s_if.arlock, s_if.arcache, s_if.arprot, s_if.arqos, s_if.arregion},
                     {2'b00, 4'h0, 3'b100, 4'h0, 4'h0});
        else n_pass++;
    endtask

    task automatic test_round_robin();
        ar_order.delete();
        m_req(1'b0, 4'd1, 32'h20, 8'd1);
        m_req(1'b1, 4'd5, 32'h40, 8'd0);
        wait_idle(40);
        n_checks++;
        if (ar_order.size() != 2 || ar_order[0] != 0 || ar_order[1] != 1)
            $display("FAIL rr_first: got order size %0d first %0d, want 0 then 1",
                     ar_order.size(), (ar_order.size() > 0) ? ar_order[0] : -1);
        else n_pass++;
        ar_order.delete();
        m_req(1'b0, 4'd2, 32'h60, 8'd0);
        m_req(1'b1, 4'd6, 32'h80, 8'd1);
        wait_idle(40);
        n_checks++;
        if (ar_order.size() != 2 || ar_order[0] != 0 || ar_order[1] != 1 || grant !== 1'b1)
            $display("FAIL rr_second: got order size %0d first %0d grant %b, want 0,1 grant 1",
                     ar_order.size(), (ar_order.size() > 0) ? ar_order[0] : -1, grant);
        else n_pass++;
    endtask

    task automatic test_single_m0();
        int p1;
        p1 = ar_pulses[1];
        sl_override = 1'b1;
        m_req(1'b0, 4'd3, 32'h10, 8'd0);
        tick();
        n_checks++;
        if ({s_if.arvalid, busy, grant, s_if.araddr, s_if.arid} !== {1'b1, 1'b1, 1'b0, 32'h10, 4'd3})
            $display("FAIL ar_latency: got %h want %h", {s_if.arvalid, busy, grant, s_if.araddr,
                     s_if.arid}, {1'b1, 1'b1, 1'b0, 32'h10, 4'd3});
        else n_pass++;
        wait_idle(20);
        sl_override = 1'b0;
        n_checks++;
        if ({grant, len_err} !== 2'b00 || ar_pulses[1] != p1)
            $display("FAIL single_m0: got grant=%b len_err=%b m1_arready_pulses=%0d want 0 0 0",
                     grant, len_err, ar_pulses[1] - p1);
        else n_pass++;
    endtask

    task automatic test_rready_stall();
        int base = m_beats[1];
        int stall = 0;
        int n = 0;
        logic stalled;
        m_req(1'b1, 4'd9, 32'h100, 8'd3);
        while (!idle_done() && n < 60) begin
            stalled = (m_beats[1] - base == 1) && (stall < 3);
            m1_if.rready = !stalled;
            if (stalled) stall++;
            tick();
            if (stalled) begin
                n_checks++;
                if (obs_s_rready !== 1'b0) $display("FAIL stall_rready: got %b want 0", obs_s_rready);
                else n_pass++;
            end
            n++;
        end
        m1_if.rready = 1'b1;
        n_checks++;
        if (m_beats[1] - base != 4 || stall != 3)
            $display("FAIL stall_beats: got %0d beats %0d stalls want 4 beats 3 stalls",
                     m_beats[1] - base, stall);
        else n_pass++;
    endtask

    task automatic test_ar_backpressure();
        int p1 = ar_pulses[1];
        ar_order.delete();
        sl_delay = 5;
        m_req(1'b1, 4'hA, 32'h200, 8'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) m_req(1'b0, 4'hB, 32'h300, 8'd0);
            n_checks++;
            if ({s_if.arvalid, s_if.araddr, s_if.arid} !== {1'b1, 32'h200, 4'hA})
                $display("FAIL ar_stable: got %h want %h", {s_if.arvalid, s_if.araddr, s_if.arid},
                         {1'b1, 32'h200, 4'hA});
            else n_pass++;
            tick();
        end
        sl_delay = 0;
        wait_idle(30);
        n_checks++;
        if (ar_pulses[1] - p1 != 1 || ar_order.size() != 2 || ar_order[0] != 1 || ar_order[1] != 0)
            $display("FAIL ar_backpressure: got %0d m1 arready pulses, order size %0d, want 1 and 1,0",
                     ar_pulses[1] - p1, ar_order.size());
        else n_pass++;
    endtask

    task automatic test_len_err_early();
        sl_rlast_at = 1;
        m_req(1'b0, 4'd4, 32'h400, 8'd3);
        wait_idle(30);
        sl_rlast_at = -1;
        n_checks++;
        if ({len_err, busy} !== 2'b10) $display("FAIL len_err_early: got %b want 10", {len_err, busy});
        else n_pass++;
        m_req(1'b0, 4'd4, 32'h500, 8'd0);
        wait_idle(20);
        n_checks++;
        if (len_err !== 1'b1) $display("FAIL len_err_sticky: got %b want 1", len_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        int base = m_beats[1];
        int n = 0;
        m_req(1'b1, 4'd7, 32'h600, 8'd7);
        while (m_beats[1] - base < 1 && n < 20) begin
            tick();
            n++;
        end
        n_checks++;
        if (m_beats[1] - base < 1) $display("FAIL mid_burst_start: got 0 beats want 1");
        else n_pass++;
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        n_checks++;
        if ({busy, grant, len_err, s_if.arvalid, s_if.rready, m1_if.rvalid} !== 6'b0)
            $display("FAIL mid_burst_reset: got %b want 000000",
                     {busy, grant, len_err, s_if.arvalid, s_if.rready, m1_if.rvalid});
        else n_pass++;
        sl_state = 0;
        s_if.rvalid = 1'b0;
        s_if.rlast = 1'b0;
        s_if.arready = 1'b0;
        exp_q.delete();
        m_req(1'b0, 4'd8, 32'h700, 8'd1);
        wait_idle(20);
    endtask

    task automatic test_len_err_late();
        sl_rlast_at = 1;
        m_req(1'b0, 4'd2, 32'h800, 8'd0);
        wait_idle(20);
        sl_rlast_at = -1;
        n_checks++;
        if ({len_err, busy} !== 2'b10) $display("FAIL len_err_late: got %b want 10", {len_err, busy});
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ARESET = 1'b1;
        {m0_if.arid, m0_if.araddr, m0_if.arlen, m0_if.arsize, m0_if.arburst, m0_if.arvalid} = '0;
        {m1_if.arid, m1_if.araddr, m1_if.arlen, m1_if.arsize, m1_if.arburst, m1_if.arvalid} = '0;
        m0_if.rready = 1'b1;
        m1_if.rready = 1'b1;
        {s_if.arready, s_if.rid, s_if.rdata, s_if.rresp, s_if.rlast, s_if.rvalid} = '0;
        sl_state = 0; sl_wait = 0; sl_delay = 0; sl_rlast_at = -1; sl_beat = 0;
        sl_override = 1'b0; sl_addr = '0; sl_len = '0; sl_id = '0;
        ar_pulses[0] = 0; ar_pulses[1] = 0; m_beats[0] = 0; m_beats[1] = 0;
        @(posedge ACLK);
        #2;
        test_reset();
        test_round_robin();
        test_single_m0();
        test_rready_stall();
        test_ar_backpressure();
        test_len_err_early();
        test_reset_mid_burst();
        test_len_err_late();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
